aes_shift_rows_pipe: RTL and testbench
======================================

AES_SHIFT_ROWS_PIPE -- requirements
Module: aes_shift_rows_pipe

Interface
REQ-001 Parameter NB, default 4: Rijndael state columns; legal values 4, 6, 8; state width W = 32*NB.
REQ-002 Parameter PIPE_DEPTH, default 1: register stages from input to output; legal values 1..4.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: synchronous active-high reset.
REQ-005 Port in_valid, input, 1: in_state/in_inv are valid this cycle.
REQ-006 Port in_ready, output, 1: the block accepts a word this cycle.
REQ-007 Port in_state, input, W: input state.
REQ-008 Port in_inv, input, 1: 0 selects ShiftRows; 1 selects InvShiftRows.
REQ-009 Port out_valid, output, 1: out_state is valid.
REQ-010 Port out_ready, input, 1: downstream accepts out_state.
REQ-011 Port out_state, output, W: permuted state.
REQ-012 Port busy, output, 1: high when any stage holds a valid word.

Function
REQ-013 Byte k = 4*c + r (row r 0..3, column c 0..NB-1) shall occupy bits [W-1-8k : W-8-8k], i.e. MSB-first, column-major.
REQ-014 Row shift offsets s_r shall be {0,1,2,3} for NB=4 and NB=6, and {0,1,3,4} for NB=8.
REQ-015 Forward mode shall produce out[r][c] = in[r][(c + s_r) mod NB].
REQ-016 Inverse mode shall produce out[r][c] = in[r][(c - s_r) mod NB], with the modulo non-negative.
REQ-017 The permutation shall be combinational ahead of stage 1; in_inv shall be sampled with the same beat as its data, so each word carries its own mode.
REQ-018 Pipeline advance enable shall be en = ~out_valid | out_ready.
REQ-019 in_ready shall equal en, combinationally.
REQ-020 When en is high, every stage shall load from its predecessor; stage 1 shall load the permuted word and the valid bit in_valid & in_ready.
REQ-021 When en is low, all stages, their valid bits and out_state shall hold unchanged.
REQ-022 Latency shall be exactly PIPE_DEPTH cycles from acceptance to out_valid under continuous out_ready.
REQ-023 Throughput shall be one word per cycle; bubbles (in_valid low) shall propagate as invalid stages and compress when out_ready is low.
REQ-024 Mixed forward and inverse words back-to-back shall each be permuted per their own in_inv, with no dead cycle.
REQ-025 out_state shall hold its last value when out_valid is low; its content is don't-care for checking.
REQ-026 Word order shall be preserved; no word shall be dropped or duplicated under any out_ready pattern.
REQ-027 busy shall be the OR of all stage valid bits.

Reset
REQ-028 While reset is high, all stage valid bits, out_valid and busy shall be 0 on the next edge, and out_state and stage data shall be 0.
REQ-029 in_ready shall be 1 during and after reset, following REQ-019 with out_valid = 0.
REQ-030 Reset mid-stream shall discard all in-flight words; a word presented in the reset cycle shall not be accepted.

Configuration
REQ-031 Macro AES_SHIFT_ROWS_BYPASS_EN, when defined, shall add a 1-bit input port in_bypass; words with in_bypass = 1 shall pass unpermuted, with bypass travelling per beat like in_inv and identical latency.
REQ-032 Without AES_SHIFT_ROWS_BYPASS_EN, the in_bypass port shall not exist and every word shall be permuted.

Verification
REQ-033 NB=4, in_inv=0, in_state=d42711aee0bf98f1b8b45de51e415230 -> out_state=d4bf5d30e0b452aeb84111f11e2798e5 after PIPE_DEPTH cycles.
REQ-034 NB=4, in_inv=1, in_state=d4bf5d30e0b452aeb84111f11e2798e5 -> out_state=d42711aee0bf98f1b8b45de51e415230; random vectors: inv(fwd(x)) == x for NB=4, 6 and 8.
REQ-035 NB=8, in_state with byte k = k (00..1f), forward -> row 3 of output column 0 equals byte 4*4+3 = 0x13 and row 2 equals byte 4*3+2 = 0x0e; check all 32 bytes against the model.
REQ-036 PIPE_DEPTH=3, 10 back-to-back words alternating in_inv, out_ready held low for cycles 4-7 -> in_ready low while stalled, all 10 outputs in order, no loss or duplication.
REQ-037 Assert reset with 2 words in flight -> out_valid=0 and busy=0 next cycle; the word presented during reset is never output.
REQ-038 With AES_SHIFT_ROWS_BYPASS_EN defined, in_bypass=1 and in_state=00112233445566778899aabbccddeeff -> out_state identical to in_state after PIPE_DEPTH cycles.

Source files
------------

// File: rtl/aes_shift_rows_pipe.sv
`default_nettype none
// ============================================================================
// Module   : aes_shift_rows_pipe
// Brief    : Rijndael ShiftRows / InvShiftRows (NB = 4, 6, 8) followed by a
//            PIPE_DEPTH-stage valid/ready register pipeline with global stall.
//            Optional build macro AES_SHIFT_ROWS_BYPASS_EN adds port in_bypass.
// Revision : 1.0 - initial release
// ============================================================================
module aes_shift_rows_pipe #(
    parameter int NB         = 4,
    parameter int PIPE_DEPTH = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [32*NB-1:0] in_state,
    input  logic            in_inv,
`ifdef AES_SHIFT_ROWS_BYPASS_EN
    input  logic            in_bypass,
`endif
    output logic            out_valid,
    input  logic            out_ready,
    output logic [32*NB-1:0] out_state,
    output logic            busy
);

    localparam int W = 32 * NB;

    logic [W-1:0]          fwd_state;
    logic [W-1:0]          inv_state;
    logic [W-1:0]          perm_state;
    logic                  en;

    logic [W-1:0]          data_q [PIPE_DEPTH];
    logic [W-1:0]          data_d [PIPE_DEPTH];
    logic [PIPE_DEPTH-1:0] valid_q;
    logic [PIPE_DEPTH-1:0] valid_d;

    // Byte k = 4*c + r sits at bits [W-1-8k -: 8]; each row rotates by its own offset.
    for (genvar c = 0; c < NB; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int SH = (NB == 8 && r >= 2) ? r + 1 : r;
            localparam int CF = (c + SH) % NB;
            localparam int CI = (c + NB - SH) % NB;
            assign fwd_state[W-1-8*(4*c+r) -: 8] = in_state[W-1-8*(4*CF+r) -: 8];
            assign inv_state[W-1-8*(4*c+r) -: 8] = in_state[W-1-8*(4*CI+r) -: 8];
        end
    end

`ifdef AES_SHIFT_ROWS_BYPASS_EN
    assign perm_state = in_bypass ? in_state : (in_inv ? inv_state : fwd_state);
`else
    assign perm_state = in_inv ? inv_state : fwd_state;
`endif

    assign en       = ~out_valid | out_ready;
    assign in_ready = en;

    // Whole pipeline advances together; a stalled output freezes every stage.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (en) begin
            data_d[0]  = perm_state;
            valid_d[0] = in_valid & in_ready;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                data_d[i]  = data_q[i-1];
                valid_d[i] = valid_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                data_q[i] <= '0;
            end
            valid_q <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign out_valid = valid_q[PIPE_DEPTH-1];
    assign out_state = data_q[PIPE_DEPTH-1];
    assign busy      = |valid_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_shift_rows_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_shift_rows_pipe
// Brief    : Scoreboard bench driving NB=4/6/8 instances in lockstep.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_shift_rows_pipe;

    localparam int PD = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, in_valid, in_inv, out_ready;
    logic         byp_now;
    logic [127:0] in4, out4;
    logic [191:0] in6, out6;
    logic [255:0] in8, out8;
    logic         rdy4, rdy6, rdy8, ov4, ov6, ov8, busy4, busy6, busy8;

`ifdef AES_SHIFT_ROWS_BYPASS_EN
    logic in_bypass;
    assign byp_now = in_bypass;
`else
    assign byp_now = 1'b0;
`endif

    aes_shift_rows_pipe #(.NB(4), .PIPE_DEPTH(PD)) u_dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy4),
        .in_state(in4), .in_inv(in_inv),
`ifdef AES_SHIFT_ROWS_BYPASS_EN
        .in_bypass(in_bypass),
`endif
        .out_valid(ov4), .out_ready(out_ready), .out_state(out4), .busy(busy4));

    aes_shift_rows_pipe #(.NB(6), .PIPE_DEPTH(PD)) u_dut6 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy6),
        .in_state(in6), .in_inv(in_inv),
`ifdef AES_SHIFT_ROWS_BYPASS_EN
        .in_bypass(in_bypass),
`endif
        .out_valid(ov6), .out_ready(out_ready), .out_state(out6), .busy(busy6));

    aes_shift_rows_pipe #(.NB(8), .PIPE_DEPTH(PD)) u_dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy8),
        .in_state(in8), .in_inv(in_inv),
`ifdef AES_SHIFT_ROWS_BYPASS_EN
        .in_bypass(in_bypass),
`endif
        .out_valid(ov8), .out_ready(out_ready), .out_state(out8), .busy(busy8));

    int           checks = 0;
    int           errors = 0;
    logic         acc;
    logic [255:0] q4[$];
    logic [255:0] q6[$];
    logic [255:0] q8[$];

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] model(input logic [255:0] x, input int nb,
                                           input logic inv, input logic byp);
        logic [255:0] y;
        int w, s, src;
        y = '0;
        w = 32 * nb;
        if (byp) return x;
        for (int c = 0; c < nb; c++) begin
            for (int r = 0; r < 4; r++) begin
                s   = (nb == 8 && r >= 2) ? r + 1 : r;
                src = inv ? (c - s + nb) % nb : (c + s) % nb;
                y[w-1-8*(4*c+r) -: 8] = x[w-1-8*(4*src+r) -: 8];
            end
        end
        return y;
    endfunction

    function automatic logic [255:0] rnd();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // Evaluates the handshakes that the coming rising edge will perform.
    task automatic evaluate();
        acc = 1'b0;
        if (reset) begin
            q4.delete(); q6.delete(); q8.delete();
            return;
        end
        if (ov4 && out_ready) begin
            if (q4.size() == 0) check_eq("spurious4", 256'(ov4), 256'(0));
            else check_eq("out4", {128'b0, out4}, q4.pop_front());
        end
        if (ov6 && out_ready) begin
            if (q6.size() == 0) check_eq("spurious6", 256'(ov6), 256'(0));
            else check_eq("out6", {64'b0, out6}, q6.pop_front());
        end
        if (ov8 && out_ready) begin
            if (q8.size() == 0) check_eq("spurious8", 256'(ov8), 256'(0));
            else check_eq("out8", out8, q8.pop_front());
        end
        if (in_valid && rdy4) begin
            q4.push_back(model({128'b0, in4}, 4, in_inv, byp_now));
            acc = 1'b1;
        end
        if (in_valid && rdy6) q6.push_back(model({64'b0, in6}, 6, in_inv, byp_now));
        if (in_valid && rdy8) q8.push_back(model(in8, 8, in_inv, byp_now));
    endtask

    task automatic tick();
        #1;
        evaluate();
        @(negedge clk);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 60 && (q4.size() + q6.size() + q8.size()) != 0; i++) tick();
        check_eq("drain_left", 256'(q4.size() + q6.size() + q8.size()), 256'(0));
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic run_single(input logic inv, input logic [255:0] d4, input logic [255:0] d6,
                              input logic [255:0] d8, output logic [255:0] o4,
                              output logic [255:0] o6, output logic [255:0] o8);
        int lat;
        in_valid  = 1'b1;
        in_inv    = inv;
        in4       = d4[127:0];
        in6       = d6[191:0];
        in8       = d8;
        out_ready = 1'b1;
        tick();
        check_eq("accept", 256'(acc), 256'(1));
        in_valid = 1'b0;
        lat      = 1;
        while (!ov4 && lat < 20) begin
            tick();
            lat++;
        end
        check_eq("latency", 256'(lat), 256'(PD));
        o4 = {128'b0, out4};
        o6 = {64'b0, out6};
        o8 = out8;
        drain();
    endtask

    logic [255:0] x4, x6, x8, y4, y6, y8, z4, z6, z8, r, cnt8;
    int           idx, cyc;

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_inv    = 1'b0;
        out_ready = 1'b1;
        in4 = '0; in6 = '0; in8 = '0;
`ifdef AES_SHIFT_ROWS_BYPASS_EN
        in_bypass = 1'b0;
`endif
        @(negedge clk);
        tick();
        tick();
        check_eq("rst_ovalid", 256'(ov4 | ov6 | ov8), 256'(0));
        check_eq("rst_busy", 256'(busy4 | busy6 | busy8), 256'(0));
        check_eq("rst_ready", 256'(rdy4), 256'(1));
        check_eq("rst_data", {128'b0, out4}, 256'(0));
        reset = 1'b0;

        // Known-answer vectors, plus NB=8 counting pattern
        for (int k = 0; k < 32; k++) cnt8[255-8*k -: 8] = 8'(k);
        r = rnd();
        run_single(1'b0, {128'b0, 128'hd42711aee0bf98f1b8b45de51e415230},
                   {64'b0, r[191:0]}, cnt8, y4, y6, y8);
        check_eq("kat_fwd", y4, {128'b0, 128'hd4bf5d30e0b452aeb84111f11e2798e5});
        check_eq("nb8_r3c0", 256'(y8[231:224]), 256'(8'h13));
        check_eq("nb8_r2c0", 256'(y8[239:232]), 256'(8'h0e));
        run_single(1'b1, {128'b0, 128'hd4bf5d30e0b452aeb84111f11e2798e5},
                   y6, y8, z4, z6, z8);
        check_eq("kat_inv", z4, {128'b0, 128'hd42711aee0bf98f1b8b45de51e415230});
        check_eq("rt6_kat", z6, {64'b0, r[191:0]});
        check_eq("rt8_cnt", z8, cnt8);

        // Random round trips through the DUT itself
        for (int t = 0; t < 3; t++) begin
            r  = rnd(); x4 = {128'b0, r[127:0]};
            r  = rnd(); x6 = {64'b0, r[191:0]};
            x8 = rnd();
            run_single(1'b0, x4, x6, x8, y4, y6, y8);
            run_single(1'b1, y4, y6, y8, z4, z6, z8);
            check_eq("rt4", z4, x4);
            check_eq("rt6", z6, x6);
            check_eq("rt8", z8, x8);
        end

        // Ten back-to-back words, alternating mode, downstream stalled on cycles 4-7
        idx = 0;
        cyc = 0;
        while (idx < 10 && cyc < 100) begin
            out_ready = !(cyc >= 4 && cyc <= 7);
            in_valid  = 1'b1;
            in_inv    = idx[0];
            r = rnd(); in4 = r[127:0];
            r = rnd(); in6 = r[191:0];
            in8 = rnd();
            #1;
            if (!out_ready && ov4) check_eq("stall_rdy", 256'(rdy4), 256'(0));
            tick();
            if (acc) idx++;
            cyc++;
        end
        check_eq("stall_sent", 256'(idx), 256'(10));
        drain();

        // Random bubbles and backpressure
        for (int t = 0; t < 80; t++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_inv    = $urandom_range(0, 1) != 0;
            r = rnd(); in4 = r[127:0];
            r = rnd(); in6 = r[191:0];
            in8 = rnd();
            tick();
        end
        drain();

        // Reset with two words in flight and a third presented during reset
        for (int t = 0; t < 2; t++) begin
            in_valid = 1'b1;
            in_inv   = 1'b0;
            r = rnd(); in4 = r[127:0]; in6 = r[191:0]; in8 = r;
            tick();
        end
        reset    = 1'b1;
        in8      = rnd();
        tick();
        check_eq("midrst_ovalid", 256'(ov4 | ov6 | ov8), 256'(0));
        check_eq("midrst_busy", 256'(busy4 | busy6 | busy8), 256'(0));
        out_ready = 1'b0;
        #1;
        check_eq("midrst_ready", 256'(rdy4), 256'(1));
        tick();
        reset = 1'b0;
        drain();

`ifdef AES_SHIFT_ROWS_BYPASS_EN
        in_bypass = 1'b1;
        run_single(1'b0, {128'b0, 128'h00112233445566778899aabbccddeeff},
                   256'(0), cnt8, y4, y6, y8);
        check_eq("bypass4", y4, {128'b0, 128'h00112233445566778899aabbccddeeff});
        check_eq("bypass8", y8, cnt8);
        in_bypass = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
